// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared definitions for the hazard scoreboard unit.
//   NUM_REGS       : architectural register count of the core
//   REG_AW         : register address width
//   hazard_cause_t : which hazard class is stalling ID (debug / coverage)
package hazard_scoreboard_unit_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);

    // Priority when several apply at once: RAW, then WAW, then CAP.
    typedef enum logic [1:0] {
        HZ_NONE = 2'd0,
        HZ_RAW  = 2'd1,
        HZ_WAW  = 2'd2,
        HZ_CAP  = 2'd3
    } hazard_cause_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline <-> hazard unit bundle.
//   master : pipeline side. It drives the ID/EX/WB fields and receives the
//            stall/flush controls, scoreboard state and debug cause.
//   slave  : hazard unit side.
interface hazard_scoreboard_unit_if
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int NUM_REGS        = hazard_scoreboard_unit_pkg::NUM_REGS,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    // ID stage
    logic          i_id_valid;
    logic [AW-1:0] i_id_rs1_addr;
    logic          i_id_rs1_used;
    logic [AW-1:0] i_id_rs2_addr;
    logic          i_id_rs2_used;
    logic [AW-1:0] i_id_rd_addr;
    logic          i_id_regfile_we;
    logic          i_id_long_lat;
    // EX stage
    logic [AW-1:0] i_ex_rd_addr;
    logic          i_ex_regfile_we;
    logic          i_ex_long_lat;
    logic          i_ex_valid;
    logic          i_ex_take_branch;
    // long-latency writeback
    logic          i_wb_valid;
    logic [AW-1:0] i_wb_rd_addr;
    // controls and state
    logic                o_stall_ifid;
    logic                o_flush_ifid;
    logic                o_flush_idex;
    logic [NUM_REGS-1:0] o_pending;
    logic [CW-1:0]       o_outstanding;
    hazard_cause_t       hz_cause;

    modport master (
        output i_id_valid, i_id_rs1_addr, i_id_rs1_used, i_id_rs2_addr,
               i_id_rs2_used, i_id_rd_addr, i_id_regfile_we, i_id_long_lat,
               i_ex_rd_addr, i_ex_regfile_we, i_ex_long_lat, i_ex_valid,
               i_ex_take_branch, i_wb_valid, i_wb_rd_addr,
        input  o_stall_ifid, o_flush_ifid, o_flush_idex, o_pending,
               o_outstanding, hz_cause
    );

    modport slave (
        input  i_id_valid, i_id_rs1_addr, i_id_rs1_used, i_id_rs2_addr,
               i_id_rs2_used, i_id_rd_addr, i_id_regfile_we, i_id_long_lat,
               i_ex_rd_addr, i_ex_regfile_we, i_ex_long_lat, i_ex_valid,
               i_ex_take_branch, i_wb_valid, i_wb_rd_addr,
        output o_stall_ifid, o_flush_ifid, o_flush_idex, o_pending,
               o_outstanding, hz_cause
    );

endinterface

// File: rtl/hazard_scoreboard_unit_reg_scoreboard.sv
// Pending-write scoreboard: one bit per register plus a count of in-flight
// long-latency writes.
//   clk, rst : clock, synchronous active-high reset
//   ex_set   : a long-latency write to ex_rd leaves EX this cycle
//   wb_clr   : a writeback retires the pending write to wb_rd
//   pending  : per-register pending bits (bit 0 is always 0)
//   count    : number of pending writes, saturating at 0..MAX_OUTSTANDING
module reg_scoreboard
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int NUM_REGS        = hazard_scoreboard_unit_pkg::NUM_REGS,
    parameter int MAX_OUTSTANDING = 4,
    localparam int AW = $clog2(NUM_REGS),
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_set,
    input  logic [AW-1:0]       ex_rd,
    input  logic                wb_clr,
    input  logic [AW-1:0]       wb_rd,
    output logic [NUM_REGS-1:0] pending,
    output logic [CW-1:0]       count
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] pending_nxt;

    // The clear is applied first, so when both target the same register the
    // set lands last and the bit stays 1.
    always_comb begin
        pending_nxt = pending;
        if (wb_clr) pending_nxt[wb_rd] = 1'b0;
        if (ex_set) pending_nxt[ex_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= pending_nxt;
            // When a set and a clear happen together, the count is unchanged.
            if (ex_set && !wb_clr && count != CNT_MAX)
                count <= count + 1'b1;
            else if (wb_clr && !ex_set && count != '0)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard detection for the pipelined core.
//   i_clk, i_rst : clock, synchronous active-high reset
//   hs (slave)   : ID/EX/WB inputs. Outputs are the stall/flush controls,
//                  the scoreboard bits, the outstanding count and the debug
//                  hazard cause.
// ID stalls on RAW/WAW against the scoreboard or against a long-latency
// write in EX, and when the outstanding queue would overflow. A taken
// branch holds both flushes for FLUSH_CYCLES cycles. All outputs are
// combinational and are forced to 0 while i_rst is high.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int NUM_REGS        = hazard_scoreboard_unit_pkg::NUM_REGS,
    parameter int MAX_OUTSTANDING = 4,
    parameter int FLUSH_CYCLES    = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    hazard_scoreboard_unit_if.slave   hs
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [CW:0]         CAP_LVL = (CW + 1)'(MAX_OUTSTANDING);
    localparam logic [FW-1:0]       FL_LOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [NUM_REGS-1:0] ONE     = {{(NUM_REGS - 1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] pending, pend_eff, wb_oh;
    logic [CW-1:0]       count;
    logic [CW:0]         count_lvl;
    logic [FW-1:0]       fl_cnt;
    logic                ex_set, wb_clr;
    logic                raw1, raw2, raw, waw, cap, any_hazard, flush_active;
    hazard_cause_t       cause;

    assign ex_set = hs.i_ex_valid & hs.i_ex_long_lat & hs.i_ex_regfile_we &
                    (hs.i_ex_rd_addr != '0);
    // Writebacks to registers that are not pending are dropped entirely.
    assign wb_clr = hs.i_wb_valid & (hs.i_wb_rd_addr != '0) &
                    pending[hs.i_wb_rd_addr];

    reg_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_sb (
        .clk     (i_clk),
        .rst     (i_rst),
        .ex_set  (ex_set),
        .ex_rd   (hs.i_ex_rd_addr),
        .wb_clr  (wb_clr),
        .wb_rd   (hs.i_wb_rd_addr),
        .pending (pending),
        .count   (count)
    );

    // The regfile is write-first, so a same-cycle writeback already
    // satisfies a reader and does not need to stall it.
    assign wb_oh    = wb_clr ? (ONE << hs.i_wb_rd_addr) : '0;
    assign pend_eff = pending & ~wb_oh;

    assign raw1 = hs.i_id_valid & hs.i_id_rs1_used & (hs.i_id_rs1_addr != '0) &
                  (pend_eff[hs.i_id_rs1_addr] |
                   (ex_set & (hs.i_ex_rd_addr == hs.i_id_rs1_addr)));
    assign raw2 = hs.i_id_valid & hs.i_id_rs2_used & (hs.i_id_rs2_addr != '0) &
                  (pend_eff[hs.i_id_rs2_addr] |
                   (ex_set & (hs.i_ex_rd_addr == hs.i_id_rs2_addr)));
    assign raw  = raw1 | raw2;
    assign waw  = hs.i_id_valid & hs.i_id_regfile_we & (hs.i_id_rd_addr != '0) &
                  (pend_eff[hs.i_id_rd_addr] |
                   (ex_set & (hs.i_ex_rd_addr == hs.i_id_rd_addr)));

    // An entry about to be claimed by EX counts against capacity.
    assign count_lvl = {1'b0, count} + {{CW{1'b0}}, ex_set};
    assign cap       = hs.i_id_valid & hs.i_id_long_lat & (count_lvl >= CAP_LVL);

    assign any_hazard = raw | waw | cap;

    // The flush window covers the branch cycle plus FLUSH_CYCLES-1 more.
    // A new branch reloads the counter, which extends the window.
    always_ff @(posedge i_clk) begin
        if (i_rst)                    fl_cnt <= '0;
        else if (hs.i_ex_take_branch) fl_cnt <= FL_LOAD;
        else if (fl_cnt != '0)        fl_cnt <= fl_cnt - 1'b1;
    end

    assign flush_active = hs.i_ex_take_branch | (fl_cnt != '0);

    always_comb begin
        cause = HZ_NONE;
        if (raw)      cause = HZ_RAW;
        else if (waw) cause = HZ_WAW;
        else if (cap) cause = HZ_CAP;
    end

    // Flush dominates stall: the stalled younger instruction is discarded.
    assign hs.o_flush_ifid  = ~i_rst & flush_active;
    assign hs.o_flush_idex  = ~i_rst & (flush_active | any_hazard);
    assign hs.o_stall_ifid  = ~i_rst & any_hazard & ~flush_active;
    assign hs.o_pending     = i_rst ? '0 : pending;
    assign hs.o_outstanding = i_rst ? '0 : count;
    assign hs.hz_cause      = i_rst ? HZ_NONE : cause;

    // A writeback to a register that is not pending points to an upstream
    // bookkeeping bug. It is dropped in hardware and flagged in simulation.
    always @(posedge i_clk) begin
        if (!i_rst && hs.i_wb_valid && hs.i_wb_rd_addr != '0)
            assert (pending[hs.i_wb_rd_addr])
            else $warning("writeback to non-pending register x%0d", hs.i_wb_rd_addr);
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;
    import hazard_scoreboard_unit_pkg::*;

    localparam int NR = 32;
    localparam int MO = 4;
    localparam int FC = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(.NUM_REGS(NR), .MAX_OUTSTANDING(MO)) hs ();

    hazard_scoreboard_unit #(
        .NUM_REGS(NR), .MAX_OUTSTANDING(MO), .FLUSH_CYCLES(FC)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .hs    (hs.slave)
    );

    typedef struct {
        logic        stall;
        logic        fl_ifid;
        logic        fl_idex;
        logic [31:0] pend;
        int          outst;
        int          cause;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // reference state
    logic [31:0] m_pend;
    int          m_cnt, m_fc;

    // last sampled outputs, for directed constant checks
    logic        s_stall, s_fifl, s_fidex;
    logic [31:0] s_pend;
    int          s_outst, s_cause;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        hs.i_id_valid = 0; hs.i_id_rs1_addr = 0; hs.i_id_rs1_used = 0;
        hs.i_id_rs2_addr = 0; hs.i_id_rs2_used = 0; hs.i_id_rd_addr = 0;
        hs.i_id_regfile_we = 0; hs.i_id_long_lat = 0;
        hs.i_ex_rd_addr = 0; hs.i_ex_regfile_we = 0; hs.i_ex_long_lat = 0;
        hs.i_ex_valid = 0; hs.i_ex_take_branch = 0;
        hs.i_wb_valid = 0; hs.i_wb_rd_addr = 0;
        rst = 0;
    endtask

    function automatic logic m_ex_set();
        return hs.i_ex_valid & hs.i_ex_long_lat & hs.i_ex_regfile_we & (hs.i_ex_rd_addr != 0);
    endfunction

    function automatic logic m_wb_clr();
        return hs.i_wb_valid & (hs.i_wb_rd_addr != 0) & m_pend[hs.i_wb_rd_addr];
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        logic [31:0] pe;
        logic es, raw, waw, cap, fa, hz;
        es = m_ex_set();
        pe = m_pend;
        if (m_wb_clr()) pe[hs.i_wb_rd_addr] = 1'b0;
        raw = (hs.i_id_valid && hs.i_id_rs1_used && hs.i_id_rs1_addr != 0 &&
               (pe[hs.i_id_rs1_addr] || (es && hs.i_ex_rd_addr == hs.i_id_rs1_addr))) ||
              (hs.i_id_valid && hs.i_id_rs2_used && hs.i_id_rs2_addr != 0 &&
               (pe[hs.i_id_rs2_addr] || (es && hs.i_ex_rd_addr == hs.i_id_rs2_addr)));
        waw = hs.i_id_valid && hs.i_id_regfile_we && hs.i_id_rd_addr != 0 &&
              (pe[hs.i_id_rd_addr] || (es && hs.i_ex_rd_addr == hs.i_id_rd_addr));
        cap = hs.i_id_valid && hs.i_id_long_lat && (m_cnt + int'(es) >= MO);
        fa  = hs.i_ex_take_branch || (m_fc != 0);
        hz  = raw || waw || cap;
        if (rst) begin
            e = '{1'b0, 1'b0, 1'b0, 32'h0, 0, 0};
        end else begin
            e.stall   = hz && !fa;
            e.fl_ifid = fa;
            e.fl_idex = fa || hz;
            e.pend    = m_pend;
            e.outst   = m_cnt;
            e.cause   = raw ? 1 : waw ? 2 : cap ? 3 : 0;
        end
        return e;
    endfunction

    task automatic model_update();
        logic es, wc;
        es = m_ex_set();
        wc = m_wb_clr();
        if (rst) begin
            m_pend = 0; m_cnt = 0; m_fc = 0;
        end else begin
            if (wc) m_pend[hs.i_wb_rd_addr] = 1'b0;
            if (es) m_pend[hs.i_ex_rd_addr] = 1'b1;
            if (es && !wc && m_cnt < MO)      m_cnt++;
            else if (wc && !es && m_cnt > 0)  m_cnt--;
            if (hs.i_ex_take_branch) m_fc = FC - 1;
            else if (m_fc > 0)       m_fc--;
        end
    endtask

    // Inputs are already driven; predict, sample mid-cycle, then advance.
    task automatic cycle();
        exp_t e;
        exp_q.push_back(model_out());
        @(negedge clk);
        s_stall = hs.o_stall_ifid; s_fifl = hs.o_flush_ifid; s_fidex = hs.o_flush_idex;
        s_pend  = hs.o_pending;    s_outst = int'(hs.o_outstanding); s_cause = int'(hs.hz_cause);
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("stall_ifid", {31'b0, s_stall}, {31'b0, e.stall});
            chk("flush_ifid", {31'b0, s_fifl},  {31'b0, e.fl_ifid});
            chk("flush_idex", {31'b0, s_fidex}, {31'b0, e.fl_idex});
            chk("pending",    s_pend,           e.pend);
            chk("outstanding", 32'(s_outst),    32'(e.outst));
            chk("cause",      32'(s_cause),     32'(e.cause));
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic ex_load(input int rd);
        hs.i_ex_valid = 1; hs.i_ex_long_lat = 1; hs.i_ex_regfile_we = 1;
        hs.i_ex_rd_addr = 5'(rd);
    endtask

    task automatic wb(input int rd);
        hs.i_wb_valid = 1; hs.i_wb_rd_addr = 5'(rd);
    endtask

    initial begin
        m_pend = 0; m_cnt = 0; m_fc = 0;
        clear_in();
        rst = 1;
        @(posedge clk); #1;
        model_update();
        rst = 1; cycle();
        chk("rst_pending", s_pend, 32'h0);
        chk("rst_outst", 32'(s_outst), 32'd0);

        // load-use
        clear_in(); ex_load(5);
        hs.i_id_valid = 1; hs.i_id_rs1_addr = 5; hs.i_id_rs1_used = 1;
        cycle();
        chk("lu_stall0", {31'b0, s_stall}, 32'd1);
        chk("lu_idex0", {31'b0, s_fidex}, 32'd1);
        clear_in();
        hs.i_id_valid = 1; hs.i_id_rs1_addr = 5; hs.i_id_rs1_used = 1;
        cycle();
        chk("lu_pend5", {31'b0, s_pend[5]}, 32'd1);
        chk("lu_stall1", {31'b0, s_stall}, 32'd1);
        wb(5); cycle();
        chk("lu_wb_stall", {31'b0, s_stall}, 32'd0);
        clear_in(); cycle();
        chk("lu_pend5_clr", {31'b0, s_pend[5]}, 32'd0);

        // WAW and set-wins
        clear_in(); ex_load(7); cycle();
        clear_in(); hs.i_id_valid = 1; hs.i_id_regfile_we = 1; hs.i_id_rd_addr = 7;
        cycle();
        chk("waw_stall", {31'b0, s_stall}, 32'd1);
        chk("waw_cause", 32'(s_cause), 32'd2);
        clear_in(); ex_load(7); wb(7); cycle();
        clear_in(); cycle();
        chk("setwins_pend7", {31'b0, s_pend[7]}, 32'd1);
        chk("setwins_cnt", 32'(s_outst), 32'd1);
        clear_in(); wb(7); cycle();

        // x0 and unused sources
        clear_in(); ex_load(0);
        hs.i_id_valid = 1; hs.i_id_rs1_addr = 0; hs.i_id_rs1_used = 1;
        cycle();
        chk("x0_stall", {31'b0, s_stall}, 32'd0);
        clear_in(); cycle();
        chk("x0_pend", s_pend, 32'h0);
        ex_load(3); cycle();
        clear_in(); hs.i_id_valid = 1; hs.i_id_rs2_addr = 3; hs.i_id_rs2_used = 0;
        cycle();
        chk("unused_rs2", {31'b0, s_stall}, 32'd0);
        clear_in(); wb(3); cycle();

        // capacity
        for (int r = 1; r <= 3; r++) begin clear_in(); ex_load(r); cycle(); end
        clear_in(); ex_load(4); hs.i_id_valid = 1; hs.i_id_long_lat = 1; cycle();
        chk("cap_stall", {31'b0, s_stall}, 32'd1);
        chk("cap_cause", 32'(s_cause), 32'd3);
        clear_in(); wb(1); hs.i_id_valid = 1; hs.i_id_long_lat = 1; cycle();
        chk("cap_full_stall", {31'b0, s_stall}, 32'd1);
        clear_in(); hs.i_id_valid = 1; hs.i_id_long_lat = 1; cycle();
        chk("cap_cnt3", 32'(s_outst), 32'd3);
        chk("cap_drop", {31'b0, s_stall}, 32'd0);
        for (int r = 2; r <= 4; r++) begin clear_in(); wb(r); cycle(); end

        // flush window with a concurrent RAW hazard
        clear_in(); ex_load(9); cycle();
        for (int k = 0; k < 5; k++) begin
            clear_in();
            hs.i_id_valid = 1; hs.i_id_rs1_addr = 9; hs.i_id_rs1_used = 1;
            hs.i_ex_take_branch = (k < 2);
            cycle();
            chk($sformatf("fl_ifid_%0d", k), {31'b0, s_fifl}, {31'b0, (k < 4)});
            chk($sformatf("fl_stall_%0d", k), {31'b0, s_stall}, {31'b0, (k == 4)});
        end
        clear_in(); wb(9); cycle();

        // reset in mid-operation
        clear_in(); ex_load(5); cycle();
        clear_in(); ex_load(7); cycle();
        clear_in(); hs.i_ex_take_branch = 1; cycle();
        chk("pre_rst_pend", s_pend, 32'h0000_00A0);
        clear_in(); rst = 1; cycle();
        chk("rst_mid_fl", {30'b0, s_fifl, s_fidex}, 32'd0);
        chk("rst_mid_pend", s_pend, 32'h0);
        clear_in(); cycle();
        chk("post_rst_outst", 32'(s_outst), 32'd0);
        chk("post_rst_fl", {31'b0, s_fifl}, 32'd0);
        clear_in(); wb(5); cycle();
        clear_in(); cycle();
        chk("spurious_wb", 32'(s_outst), 32'd0);

        // constrained random traffic against the model
        for (int n = 0; n < 400; n++) begin
            clear_in();
            hs.i_id_valid = 1'($urandom);
            hs.i_id_rs1_addr = 5'($urandom); hs.i_id_rs1_used = 1'($urandom);
            hs.i_id_rs2_addr = 5'($urandom); hs.i_id_rs2_used = 1'($urandom);
            hs.i_id_rd_addr = 5'($urandom);  hs.i_id_regfile_we = 1'($urandom);
            hs.i_id_long_lat = 1'($urandom);
            hs.i_ex_valid = 1'($urandom); hs.i_ex_regfile_we = 1'($urandom);
            hs.i_ex_rd_addr = 5'($urandom);
            hs.i_ex_long_lat = (m_cnt < MO) && !m_pend[hs.i_ex_rd_addr] && ($urandom_range(0, 2) == 0);
            hs.i_ex_take_branch = ($urandom_range(0, 7) == 0);
            if (m_pend != 0 && $urandom_range(0, 1) == 1) begin
                for (int t = 0; t < 64; t++) begin
                    int idx;
                    idx = $urandom_range(1, NR - 1);
                    if (m_pend[idx]) begin wb(idx); break; end
                end
            end
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
